cnn_weight_loader: RTL and testbench



---
 rtl/cnn_pkg.sv | 26 ++
 rtl/cnn_weight_loader.sv | 136 +++++++++++++
 tb/tb_cnn_weight_loader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN weight loader: FSM state encoding,
// default widths and the filter-index to one-hot decode.
package cnn_pkg;

  localparam int unsigned CNN_MAX_FILTERS = 32;
  localparam int unsigned CNN_DATA_W      = 16;
  localparam int unsigned CNN_NF_W        = 6;
  localparam int unsigned CNN_DIM_W       = 5;
  localparam int unsigned CNN_ELEM_W      = 10;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_LOAD,
    WL_DONE
  } wl_state_e;

  function automatic logic [CNN_MAX_FILTERS-1:0] onehot(input logic [CNN_NF_W-1:0] idx);
    logic [CNN_MAX_FILTERS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < CNN_MAX_FILTERS; i++) begin
      if (idx == CNN_NF_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/cnn_weight_loader.sv
// Streams 2-element weight beats into the selected per-filter FIFO, counting
// k*k elements per filter and pulsing done after the last filter.
module cnn_weight_loader
  import cnn_pkg::*;
#(
  parameter int unsigned MAX_FILTERS = CNN_MAX_FILTERS,
  parameter int unsigned DATA_W      = CNN_DATA_W,
  parameter int unsigned NF_W        = CNN_NF_W,
  parameter int unsigned DIM_W       = CNN_DIM_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NF_W-1:0]        num_filters_i,
  input  logic [DIM_W-1:0]       weight_dim_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [2*DATA_W-1:0]    s_data_i,
  input  logic [MAX_FILTERS-1:0] fifo_full_i,
  output logic [MAX_FILTERS-1:0] fifo_wr_en_o,
  output logic [2*DATA_W-1:0]    fifo_data_o,
  output logic                   fifo_lane1_vld_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned ELEM_W = CNN_ELEM_W;

  wl_state_e         state_q, state_d;
  logic [NF_W-1:0]   nf_q, nf_d;
  logic [NF_W-1:0]   filt_idx_q, filt_idx_d;
  logic [ELEM_W-1:0] elems_q, elems_d;
  logic [ELEM_W-1:0] elem_cnt_q, elem_cnt_d;
  logic              err_q, err_d;

  logic [MAX_FILTERS-1:0] sel;
  logic                   sel_full;
  logic                   accept;
  logic                   cfg_bad;
  logic                   mid_beat;
  logic                   exact_end;
  logic                   last_filt;
  logic [ELEM_W:0]        cnt_plus2;

  // Datapath and handshake are purely combinational so a write lands in the
  // same cycle the beat is accepted.
  always_comb begin
    sel              = onehot(filt_idx_q);
    sel_full         = |(fifo_full_i & sel);
    s_ready_o        = (state_q == WL_LOAD) && !sel_full;
    accept           = s_valid_i && s_ready_o;
    cnt_plus2        = {1'b0, elem_cnt_q} + (ELEM_W+1)'(2);
    mid_beat         = cnt_plus2 < {1'b0, elems_q};
    exact_end        = cnt_plus2 == {1'b0, elems_q};
    last_filt        = filt_idx_q == (nf_q - NF_W'(1));
    fifo_wr_en_o     = accept ? sel : '0;
    fifo_data_o      = s_data_i;
    fifo_lane1_vld_o = accept && (mid_beat || exact_end);
    busy_o           = state_q == WL_LOAD;
    done_o           = state_q == WL_DONE;
    err_o            = err_q;
    cfg_bad          = (num_filters_i == '0) ||
                       (num_filters_i > NF_W'(MAX_FILTERS)) ||
                       (weight_dim_i == '0);
  end

  always_comb begin
    state_d    = state_q;
    nf_d       = nf_q;
    elems_d    = elems_q;
    filt_idx_d = filt_idx_q;
    elem_cnt_d = elem_cnt_q;
    err_d      = 1'b0;

    if (abort_i) begin
      state_d    = WL_IDLE;
      filt_idx_d = '0;
      elem_cnt_d = '0;
    end else begin
      unique case (state_q)
        WL_IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              state_d    = WL_LOAD;
              nf_d       = num_filters_i;
              elems_d    = ELEM_W'(weight_dim_i) * ELEM_W'(weight_dim_i);
              filt_idx_d = '0;
              elem_cnt_d = '0;
            end
          end
        end
        WL_LOAD: begin
          if (accept) begin
            if (mid_beat) begin
              elem_cnt_d = cnt_plus2[ELEM_W-1:0];
            end else begin
              // Odd element counts drop lane1 here; the next filter starts fresh.
              elem_cnt_d = '0;
              if (last_filt) begin
                state_d    = WL_DONE;
                filt_idx_d = '0;
              end else begin
                filt_idx_d = filt_idx_q + NF_W'(1);
              end
            end
          end
        end
        WL_DONE: state_d = WL_IDLE;
        default: state_d = WL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= WL_IDLE;
      nf_q       <= '0;
      elems_q    <= '0;
      filt_idx_q <= '0;
      elem_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nf_q       <= nf_d;
      elems_q    <= elems_d;
      filt_idx_q <= filt_idx_d;
      elem_cnt_q <= elem_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_cnn_weight_loader.sv
// Randomized bench for cnn_weight_loader: a queue of expected beats per load
// is checked every cycle, plus literal expectations for the directed scenarios.
module tb_cnn_weight_loader;

  localparam int MF  = 32;
  localparam int DW  = 16;
  localparam int NFW = 6;
  localparam int DMW = 5;

  logic            clk  = 1'b0;
  logic            nrst = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [NFW-1:0]  num_filters_i = '0;
  logic [DMW-1:0]  weight_dim_i = '0;
  logic            s_valid_i = 1'b0;
  logic            s_ready_o;
  logic [2*DW-1:0] s_data_i = '0;
  logic [MF-1:0]   fifo_full_i = '0;
  logic [MF-1:0]   fifo_wr_en_o;
  logic [2*DW-1:0] fifo_data_o;
  logic            fifo_lane1_vld_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  always #5 clk = ~clk;

  cnn_weight_loader #(
    .MAX_FILTERS(MF),
    .DATA_W     (DW),
    .NF_W       (NFW),
    .DIM_W      (DMW)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .num_filters_i   (num_filters_i),
    .weight_dim_i    (weight_dim_i),
    .s_valid_i       (s_valid_i),
    .s_ready_o       (s_ready_o),
    .s_data_i        (s_data_i),
    .fifo_full_i     (fifo_full_i),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_lane1_vld_o(fifo_lane1_vld_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected write sequence of a load is a queue of beats.
  typedef struct { int f; bit l1; } beat_t;
  typedef struct { logic [MF-1:0] wr; logic l1; } wlog_t;

  beat_t mq[$];
  wlog_t wlog[$];
  bit    m_busy = 0;
  bit    m_done = 0;
  bit    m_err  = 0;
  int    done_cnt = 0;
  int    err_cnt  = 0;

  task automatic build_load(input int nf, input int k);
    int elems;
    elems = k * k;
    mq.delete();
    for (int f = 0; f < nf; f++)
      for (int e = 0; e < elems; e += 2)
        mq.push_back('{f: f, l1: (e + 1 < elems)});
  endtask

  always @(negedge clk) begin
    logic [MF-1:0] ewr;
    logic          erdy, eacc, el1;
    bit            nd, ne;
    int            nf, k;
    if (!nrst) begin
      check("rst_ready", s_ready_o, 0);
      check("rst_wr_en", fifo_wr_en_o, 0);
      check("rst_lane1", fifo_lane1_vld_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      mq.delete();
      m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      erdy = 1'b0;
      if (m_busy) erdy = !fifo_full_i[mq[0].f];
      eacc = erdy && s_valid_i;
      ewr  = '0;
      el1  = 1'b0;
      if (eacc) begin
        ewr = MF'(1) << mq[0].f;
        el1 = mq[0].l1;
      end
      check("s_ready", s_ready_o, erdy);
      check("wr_en", fifo_wr_en_o, ewr);
      check("lane1_vld", fifo_lane1_vld_o, el1);
      check("busy", busy_o, m_busy);
      check("done", done_o, m_done);
      check("err", err_o, m_err);
      if (eacc) check("wr_data", fifo_data_o, s_data_i);
      if (fifo_wr_en_o != '0) wlog.push_back('{wr: fifo_wr_en_o, l1: fifo_lane1_vld_o});
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;

      nd = 0; ne = 0;
      nf = int'(num_filters_i);
      k  = int'(weight_dim_i);
      if (abort_i) begin
        m_busy = 0;
        mq.delete();
      end else if (m_busy) begin
        if (eacc) begin
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            m_busy = 0;
            nd = 1;
          end
        end
      end else if (!m_done && start_i) begin
        if (nf == 0 || nf > MF || k == 0) ne = 1;
        else begin
          build_load(nf, k);
          m_busy = 1;
        end
      end
      m_done = nd;
      m_err  = ne;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input int nf, input int k);
    num_filters_i = NFW'(nf);
    weight_dim_i  = DMW'(k);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic stream_until_done(input string name, input int budget, input int vpct, input int fpct);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      s_valid_i = ($urandom_range(99) < vpct);
      s_data_i  = $urandom;
      for (int b = 0; b < MF; b++) fifo_full_i[b] = ($urandom_range(99) < fpct);
      tick();
      if (done_cnt != d0) got = 1;
    end
    s_valid_i   = 1'b0;
    fifo_full_i = '0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done_o expected done_o within %0d cycles", name, budget);
    end
    tick();
    tick();
    check({name, "_single_done"}, done_cnt, d0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $fatal(1);
  end

  initial begin
    int d0, e0, l0;
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // 1) nf=3, k=3, continuous valid
    wlog.delete();
    d0 = done_cnt;
    start_cfg(3, 3);
    check("t1_busy", busy_o, 1);
    stream_until_done("t1", 200, 100, 0);
    check("t1_nwr", wlog.size(), 15);
    check("t1_w0", wlog[0].wr, 32'h1);
    check("t1_w0_l1", wlog[0].l1, 1);
    check("t1_w4", wlog[4].wr, 32'h1);
    check("t1_w4_l1", wlog[4].l1, 0);
    check("t1_w5", wlog[5].wr, 32'h2);
    check("t1_w14", wlog[14].wr, 32'h4);
    check("t1_w14_l1", wlog[14].l1, 0);

    // 2) nf=2, k=2, FIFO 1 full for 4 cycles at filter 1 start
    wlog.delete();
    start_cfg(2, 2);
    s_valid_i = 1'b1;
    fifo_full_i = 32'h2;
    for (int i = 0; i < 2; i++) begin
      s_data_i = $urandom;
      #2;
      check("t2_f0_wr", fifo_wr_en_o, 32'h1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t2_stall_ready", s_ready_o, 0);
      check("t2_stall_wr", fifo_wr_en_o, 0);
      tick();
    end
    fifo_full_i = '0;
    #2;
    check("t2_resume_wr", fifo_wr_en_o, 32'h2);
    stream_until_done("t2", 50, 100, 0);
    check("t2_nwr", wlog.size(), 4);

    // 3) nf=32, k=2, random gaps and backpressure
    wlog.delete();
    start_cfg(32, 2);
    stream_until_done("t3", 3000, 50, 20);
    check("t3_nwr", wlog.size(), 64);
    for (int i = 0; i < 64 && i < wlog.size(); i++) begin
      logic [MF-1:0] e;
      e = MF'(1) << (i / 2);
      check("t3_order", wlog[i].wr, e);
    end

    // 4) invalid configurations
    wlog.delete();
    e0 = err_cnt;
    start_cfg(0, 3);
    tick();
    start_cfg(33, 3);
    tick();
    start_cfg(5, 0);
    tick();
    check("t4_err_cnt", err_cnt, e0 + 3);
    check("t4_nwr", wlog.size(), 0);
    check("t4_busy", busy_o, 0);

    // 5) abort after 7 beats of nf=4, k=4, then reload
    wlog.delete();
    d0 = done_cnt;
    start_cfg(4, 4);
    s_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_data_i = $urandom;
      tick();
    end
    abort_i = 1'b1;
    #2;
    check("t5_abort_wr", fifo_wr_en_o, 32'h1);
    tick();
    abort_i = 1'b0;
    s_valid_i = 1'b0;
    check("t5_idle_busy", busy_o, 0);
    tick();
    tick();
    check("t5_no_done", done_cnt, d0);
    check("t5_nwr_abort", wlog.size(), 8);
    start_cfg(4, 4);
    stream_until_done("t5", 800, 70, 10);
    check("t5_nwr", wlog.size(), 40);
    if (wlog.size() >= 17) begin
      for (int i = 8; i < 16; i++) check("t5_refill_f0", wlog[i].wr, 32'h1);
      check("t5_f1_start", wlog[16].wr, 32'h2);
    end

    // 6) start during LOAD ignored; async reset mid-load
    wlog.delete();
    start_cfg(2, 3);
    s_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    num_filters_i = NFW'(5);
    weight_dim_i  = DMW'(1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    #1;
    check("t6_busy_kept", busy_o, 1);
    check("t6_cfg_wr", fifo_wr_en_o, 32'h1);
    check("t6_cfg_l1", fifo_lane1_vld_o, 0);
    tick();
    #1;
    check("t6_next_filter", fifo_wr_en_o, 32'h2);
    nrst = 1'b0;
    #1;
    check("t6_rst_ready", s_ready_o, 0);
    check("t6_rst_wr", fifo_wr_en_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_err", err_o, 0);
    s_valid_i = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
    s_valid_i = 1'b1;
    start_cfg(1, 1);
    #1;
    check("t6_k1_wr", fifo_wr_en_o, 32'h1);
    check("t6_k1_l1", fifo_lane1_vld_o, 0);
    stream_until_done("t6", 50, 100, 0);

    // random configurations
    for (int r = 0; r < 4; r++) begin
      int nf, k;
      nf = $urandom_range(32, 1);
      k  = $urandom_range(5, 1);
      wlog.delete();
      start_cfg(nf, k);
      stream_until_done("rand", 5000, 60, 15);
      l0 = nf * ((k * k + 1) / 2);
      check("rand_nwr", wlog.size(), l0);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
